// File: rtl/systolic_skew_feeder.sv
// Operand sequencer for systolic_array: buffers K-slices of A/B in per-lane FIFOs and replays them as skewed waves.
// Build macro SKEW_FEEDER_ZERO_PAD_EN makes every lane valid in every wave, padding non-participants with zeros.
module systolic_skew_feeder #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [width_p*array_height_p-1:0]   a_i,
  input  logic [width_p*array_width_p-1:0]    b_i,
  input  logic                                slice_valid_i,
  input  logic                                last_i,
  output logic                                slice_ready_o,
  output logic [width_p*array_height_p-1:0]   row_o,
  output logic [array_height_p-1:0]           row_valid_o,
  input  logic [array_height_p-1:0]           row_ready_i,
  output logic [array_height_p-1:0]           flush_o,
  output logic [width_p*array_width_p-1:0]    col_o,
  output logic [array_width_p-1:0]            col_valid_o,
  input  logic [array_width_p-1:0]            col_ready_i
);
  localparam int H    = array_height_p;
  localparam int W    = array_width_p;
  localparam int L    = H + W;
  localparam int MAXL = (H > W) ? H : W;
  localparam int CW   = $clog2(depth_p + MAXL) + 8;
  localparam int AW   = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int NW   = $clog2(depth_p + 1);
`ifdef SKEW_FEEDER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  function automatic logic [AW-1:0] nxt_ptr(input logic [AW-1:0] p);
    return (p == AW'(depth_p - 1)) ? '0 : p + AW'(1);
  endfunction

  // Lanes 0..H-1 are row lanes, H..L-1 are column lanes.
  logic [L-1:0][width_p-1:0] dat_q;
  logic [L-1:0][width_p-1:0] push_data;
  logic [L-1:0][width_p-1:0] head;
  logic [L-1:0][CW-1:0]      lane_d;
  logic [L-1:0]              vld_q, part_q, rdy, full, pop, avail;
  logic [L-1:0]              lane_part, lane_need, lane_last;
  logic [H-1:0]              flush_q;
  logic [CW-1:0]             w_q, n_q, k_q;
  logic                      done_q, active_q;

  logic          accept, done_d, wave_done, product_done, issue;
  logic [CW-1:0] n_d, k_d, lim_d, cand_w, last_w;

  assign slice_ready_o = ~reset_i & ~(|full) & ~done_q;
  assign accept        = slice_valid_i & slice_ready_o;
  assign n_d           = n_q + CW'(accept);
  assign done_d        = done_q | (accept & last_i);
  assign k_d           = (accept & last_i) ? n_q + CW'(1) : k_q;
  assign lim_d         = done_d ? k_d : n_d;
  assign wave_done     = active_q & ~(|(vld_q & ~rdy));
  assign last_w        = k_q + CW'(MAXL) - CW'(2);
  assign product_done  = wave_done & done_q & (w_q == last_w);
  // The next wave may launch on the same edge the current one completes.
  assign cand_w        = active_q ? w_q + CW'(1) : w_q;
  assign issue         = (~active_q | wave_done) & ~product_done
                       & (&(avail | ~lane_need)) & (|lane_part);

  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    localparam int OFF = (gi < H) ? gi : gi - H;
    logic [width_p-1:0] mem_q [depth_p];
    logic [AW-1:0]      rd_q, wr_q, rd_ap;
    logic [NW-1:0]      cnt_q, cnt_ap;
    logic               ge;

    if (gi < H) begin : g_row
      assign push_data[gi] = a_i[width_p*gi +: width_p];
      assign rdy[gi]       = row_ready_i[gi];
      assign row_o[width_p*gi +: width_p] = dat_q[gi];
    end else begin : g_col
      assign push_data[gi] = b_i[width_p*(gi-H) +: width_p];
      assign rdy[gi]       = col_ready_i[gi-H];
      assign col_o[width_p*(gi-H) +: width_p] = dat_q[gi];
    end

    assign full[gi]  = (cnt_q == NW'(depth_p));
    assign pop[gi]   = vld_q[gi] & rdy[gi] & part_q[gi];
    assign cnt_ap    = cnt_q - NW'(pop[gi]);
    assign rd_ap     = pop[gi] ? nxt_ptr(rd_q) : rd_q;
    // An empty FIFO being pushed this cycle forwards the incoming operand.
    assign avail[gi] = (cnt_ap != '0) | accept;
    assign head[gi]  = (cnt_ap != '0) ? mem_q[rd_ap] : push_data[gi];

    assign ge            = (cand_w >= CW'(OFF));
    assign lane_d[gi]    = cand_w - CW'(OFF);
    assign lane_part[gi] = ge & (lane_d[gi] < lim_d);
    assign lane_need[gi] = ge & ~(done_d & (lane_d[gi] >= k_d));
    assign lane_last[gi] = done_d & (lane_d[gi] == k_d - CW'(1));

    always_ff @(posedge clk_i) begin
      if (accept) mem_q[wr_q] <= push_data[gi];
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        rd_q  <= rd_ap;
        cnt_q <= cnt_ap + NW'(accept);
        if (accept) wr_q <= nxt_ptr(wr_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      vld_q    <= '0;
      part_q   <= '0;
      flush_q  <= '0;
      dat_q    <= '0;
    end else begin
      n_q      <= product_done ? '0 : n_d;
      done_q   <= product_done ? 1'b0 : done_d;
      k_q      <= k_d;
      active_q <= issue | (active_q & ~wave_done);
      if (wave_done) w_q <= product_done ? '0 : w_q + CW'(1);
      for (int l = 0; l < L; l++) begin
        if (issue) begin
          vld_q[l]  <= PAD | lane_part[l];
          part_q[l] <= lane_part[l];
          dat_q[l]  <= lane_part[l] ? head[l] : '0;
          if (l < H) flush_q[l] <= lane_part[l] & lane_last[l];
        end else if (vld_q[l] & rdy[l]) begin
          vld_q[l]  <= 1'b0;
          part_q[l] <= 1'b0;
          dat_q[l]  <= '0;
          if (l < H) flush_q[l] <= 1'b0;
        end
      end
    end
  end

  assign row_valid_o = vld_q[H-1:0];
  assign col_valid_o = vld_q[L-1:H];
  assign flush_o     = flush_q;

endmodule
